spi_flash_master: RTL and testbench
===================================

Name: spi_flash_master

Overview:
- SPI mode-0 master that sits directly upstream of the W25Q32 flash model and drives its spi_clk, cs_n and mosi pins, and samples its miso pin.
- Accepts one command descriptor per transaction: opcode, optional 24-bit address, optional read-data byte count.
- Serialises the descriptor MSB-first, then returns read bytes as a pulsed stream.
- Gives system logic (boot loader, erase/readback engines) a byte-level flash access port.

Parameters:
- CLK_DIV, 4, clk_i cycles per spi_clk half-period; legal minimum 2, so the slave's edge detector sees every edge.
- CS_GAP, 8, minimum clk_i cycles cs_n stays high between transactions.
- LEN_W, 8, width of the read byte count.

Ports:
- clk_i  in  1  system clock; all logic is clocked on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  descriptor valid.
- cmd_ready  out  1  master idle; the descriptor is accepted when valid && ready.
- cmd_op  in  8  opcode byte.
- cmd_addr_en  in  1  send the 3-byte address after the opcode.
- cmd_addr  in  24  flash address, sent MSB-first.
- cmd_len  in  LEN_W  number of read bytes; 0 means no data phase.
- rd_valid  out  1  one-cycle pulse; rd_data is valid.
- rd_data  out  8  received byte.
- done  out  1  one-cycle pulse on the cycle cs_n returns high.
- busy  out  1  equals ~cmd_ready.
- spi_clk  out  1  serial clock; idles low.
- cs_n  out  1  chip select, active low.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.
- wp_n  out  1  tied 1.
- hold_n  out  1  tied 1.

Behaviour:
- Reset values: cs_n=1, spi_clk=0, mosi=0, cmd_ready=1, rd_valid=0, rd_data=0, done=0.
- Reset mid-transaction: all outputs take their reset values on the next edge; the FSM goes to IDLE; no done or rd_valid pulse is issued.
- Descriptor handling: all descriptor fields are captured on acceptance. cmd_ready drops on the following cycle. cmd_valid is ignored while busy.
- FSM states: IDLE -> SETUP -> OP -> [ADDR] -> [READ] -> HOLD -> GAP -> IDLE.
- IDLE: cmd_ready=1. On acceptance, cs_n goes low on the next cycle, mosi=cmd_op[7], and the FSM enters SETUP.
- SETUP: lasts CLK_DIV cycles with spi_clk low.
- Bit slot (OP, ADDR and READ states):
  - spi_clk is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - mosi updates only on the first low cycle of a slot. The first bit is the exception: it is already driven in SETUP.
  - miso is sampled on the last high cycle of each slot.
- OP: 8 slots carrying cmd_op[7:0].
  - Next state is ADDR if cmd_addr_en.
  - Otherwise READ if cmd_len != 0.
  - Otherwise HOLD.
- ADDR: 24 slots carrying cmd_addr[23:0]. Next state is READ if cmd_len != 0, otherwise HOLD.
- READ: mosi=0.
  - Bits are shifted into an 8-bit register MSB-first.
  - After the 8th sample: rd_data = the byte, and rd_valid pulses in the next cycle.
  - There is no backpressure.
  - A down-counter loaded with cmd_len runs the phase; after the last byte the FSM enters HOLD.
- HOLD: spi_clk=0 for CLK_DIV cycles, then cs_n=1, done pulses on that same cycle, mosi=0, and the FSM enters GAP.
- GAP: CS_GAP cycles with cs_n high, then IDLE. Back-to-back descriptors therefore always see cs_n high for at least CS_GAP cycles.
- cs_n low duration, exact: CLK_DIV*(2 + 2*8*(1 + 3*cmd_addr_en + cmd_len)) cycles.
- spi_clk is never high while cs_n transitions. Every transaction ends with spi_clk low.
- cmd_len=max (2^LEN_W−1) is legal; counters must not wrap early.
- Opcodes are not interpreted; the descriptor fields alone define the framing.

Test Plan:
- WREN: op=0x06, addr_en=0, len=0, CLK_DIV=4 -> cs_n low for exactly 72 cycles; mosi sampled at rising spi_clk edges = 0,0,0,0,0,1,1,0; 8 spi_clk pulses; one done pulse; zero rd_valid.
- Sector erase: op=0x20, addr_en=1, addr=0x012345, len=0 -> 32 rising edges; captured bit stream 0x20,0x01,0x23,0x45; cs_n low for 264 cycles.
- Read vs bench slave: op=0x03, addr=0x000100, len=3; slave returns 0xA5,0x3C,0xFF on falling edges -> rd_valid pulses 3 times with rd_data 0xA5, 0x3C, 0xFF; 56 rising edges; mosi=0 throughout the data phase.
- Back-to-back: cmd_valid held high with two WREN descriptors -> second cs_n fall at least CS_GAP+1 cycles after the first cs_n rise; cmd_ready=0 throughout the first transaction; the second descriptor is accepted only once.
- Reset mid-read: assert rst during the 2nd data byte -> next cycle cs_n=1, spi_clk=0, cmd_ready=1; no rd_valid or done pulse; a following WREN transaction is correct.
- CLK_DIV=2 run of the read test against the W25Q32 model preloaded with 0x5A at 0x000010 -> rd_data=0x5A.

Source files
------------

// File: rtl/spi_flash_master.sv
// ---------------------------------------------------------------------------
// spi_flash_master
// SPI mode-0 master giving system logic byte-level access to a serial flash.
// One descriptor per transaction: opcode, optional 24-bit address and an
// optional read byte count. The descriptor is serialised MSB-first, then read
// bytes are returned as single-cycle rd_valid pulses.
//
// Ports
//   clk_i        system clock, rising edge
//   rst          synchronous active-high reset
//   cmd_valid    descriptor valid
//   cmd_ready    master idle; accept on cmd_valid && cmd_ready
//   cmd_op       opcode byte
//   cmd_addr_en  send 3 address bytes after the opcode
//   cmd_addr     24-bit flash address
//   cmd_len      read byte count, 0 = no data phase
//   rd_valid     one-cycle pulse, rd_data valid
//   rd_data      received byte
//   done         one-cycle pulse when cs_n returns high
//   busy         inverse of cmd_ready
//   spi_clk      serial clock, idles low
//   cs_n         chip select, active low
//   mosi         serial data out
//   miso         serial data in
//   wp_n, hold_n tied high
// ---------------------------------------------------------------------------
module spi_flash_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 8,
  parameter int unsigned LEN_W   = 8
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_op,
  input  logic             cmd_addr_en,
  input  logic [23:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             rd_valid,
  output logic [7:0]       rd_data,
  output logic             done,
  output logic             busy,
  output logic             spi_clk,
  output logic             cs_n,
  output logic             mosi,
  input  logic             miso,
  output logic             wp_n,
  output logic             hold_n
);

  localparam int unsigned CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_OP,
    S_ADDR,
    S_READ,
    S_HOLD,
    S_GAP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [CNT_W-1:0] r_div;       // cycle counter within a half-period / gap
  logic [4:0]       r_bit;       // slots remaining in the current phase, minus one
  logic [LEN_W-1:0] r_len;       // read bytes remaining
  logic             r_addr_en;
  logic [30:0]      r_tx;        // cmd_op[6:0] + cmd_addr; cmd_op[7] goes straight to mosi
  logic [7:0]       r_rx;

  logic             r_sclk;
  logic             r_cs_n;
  logic             r_mosi;
  logic             r_ready;
  logic             r_busy;
  logic             r_rd_valid;
  logic [7:0]       r_rd_data;
  logic             r_done;

  logic             w_accept;
  logic             w_half_end;
  logic             w_gap_end;
  logic             w_in_slot;
  logic             w_slot_end;
  logic             w_last_bit;
  logic             w_rd_push;
  logic [7:0]       w_rx_nxt;

  logic             w_sclk_nxt;
  logic             w_cs_n_nxt;
  logic             w_mosi_nxt;
  logic             w_ready_nxt;
  logic             w_busy_nxt;
  logic             w_rd_valid_nxt;
  logic [7:0]       w_rd_data_nxt;
  logic             w_done_nxt;

  assign w_accept   = cmd_valid & r_ready;
  assign w_half_end = (r_div == CNT_W'(CLK_DIV - 1));
  assign w_gap_end  = (r_div == CNT_W'(CS_GAP - 1));
  assign w_in_slot  = (r_state == S_OP) || (r_state == S_ADDR) || (r_state == S_READ);
  // spi_clk doubles as the slot phase: a slot ends on the last high cycle
  assign w_slot_end = w_in_slot & r_sclk & w_half_end;
  assign w_last_bit = (r_bit == 5'd0);
  assign w_rx_nxt   = {r_rx[6:0], miso};
  assign w_rd_push  = (r_state == S_READ) & w_slot_end & w_last_bit;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_SETUP;
      end
      S_SETUP: begin
        if (w_half_end) w_state_nxt = S_OP;
      end
      S_OP: begin
        if (w_slot_end && w_last_bit) begin
          if (r_addr_en)            w_state_nxt = S_ADDR;
          else if (r_len != '0)     w_state_nxt = S_READ;
          else                      w_state_nxt = S_HOLD;
        end
      end
      S_ADDR: begin
        if (w_slot_end && w_last_bit) begin
          w_state_nxt = (r_len != '0) ? S_READ : S_HOLD;
        end
      end
      S_READ: begin
        if (w_slot_end && w_last_bit && (r_len == LEN_W'(1))) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (w_half_end) w_state_nxt = S_GAP;
      end
      S_GAP: begin
        if (w_gap_end) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered pins
  always_comb begin
    w_cs_n_nxt     = (w_state_nxt == S_IDLE) || (w_state_nxt == S_GAP);
    w_ready_nxt    = (w_state_nxt == S_IDLE);
    w_busy_nxt     = (w_state_nxt != S_IDLE);
    w_done_nxt     = (r_state == S_HOLD) && (w_state_nxt == S_GAP);
    w_rd_valid_nxt = w_rd_push;
    w_rd_data_nxt  = w_rd_push ? w_rx_nxt : r_rd_data;
    w_sclk_nxt     = 1'b0;
    if (w_in_slot) begin
      w_sclk_nxt = w_half_end ? ~r_sclk : r_sclk;
    end
    w_mosi_nxt = r_mosi;
    if (w_accept) begin
      w_mosi_nxt = cmd_op[7];
    end else if (w_slot_end) begin
      // next bit at the start of the following slot; zero once shifting ends
      w_mosi_nxt = ((w_state_nxt == S_OP) || (w_state_nxt == S_ADDR)) ? r_tx[30] : 1'b0;
    end
  end

  // Registered pins
  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_sclk     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_mosi     <= 1'b0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= 8'd0;
      r_done     <= 1'b0;
    end else begin
      r_sclk     <= w_sclk_nxt;
      r_cs_n     <= w_cs_n_nxt;
      r_mosi     <= w_mosi_nxt;
      r_ready    <= w_ready_nxt;
      r_busy     <= w_busy_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Descriptor capture, timing counters and shift registers
  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_div     <= '0;
      r_bit     <= 5'd0;
      r_len     <= '0;
      r_addr_en <= 1'b0;
      r_tx      <= 31'd0;
      r_rx      <= 8'd0;
    end else if (w_accept) begin
      r_div     <= '0;
      r_bit     <= 5'd7;
      r_len     <= cmd_len;
      r_addr_en <= cmd_addr_en;
      r_tx      <= {cmd_op[6:0], cmd_addr};
    end else begin
      case (r_state)
        S_SETUP, S_HOLD: begin
          r_div <= w_half_end ? '0 : r_div + CNT_W'(1);
        end
        S_OP, S_ADDR, S_READ: begin
          r_div <= w_half_end ? '0 : r_div + CNT_W'(1);
          if (w_slot_end) begin
            if (w_last_bit) begin
              r_bit <= ((r_state == S_OP) && (w_state_nxt == S_ADDR)) ? 5'd23 : 5'd7;
            end else begin
              r_bit <= r_bit - 5'd1;
            end
            if ((w_state_nxt == S_OP) || (w_state_nxt == S_ADDR)) begin
              r_tx <= {r_tx[29:0], 1'b0};
            end
            if (r_state == S_READ) begin
              r_rx <= w_rx_nxt;
              if (w_last_bit) r_len <= r_len - LEN_W'(1);
            end
          end
        end
        S_GAP: begin
          r_div <= w_gap_end ? '0 : r_div + CNT_W'(1);
        end
        default: begin
          r_div <= '0;
        end
      endcase
    end
  end

  assign spi_clk   = r_sclk;
  assign cs_n      = r_cs_n;
  assign mosi      = r_mosi;
  assign cmd_ready = r_ready;
  assign busy      = r_busy;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign done      = r_done;
  assign wp_n      = 1'b1;
  assign hold_n    = 1'b1;

endmodule

// File: tb/tb_spi_flash_master.sv
// ---------------------------------------------------------------------------
// tb_spi_flash_master
// Directed bench: a table of descriptors with hand-computed framing, plus
// back-to-back, reset-mid-read and a CLK_DIV=2 read against a small flash
// memory model.
// ---------------------------------------------------------------------------
module tb_spi_flash_master;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned CS_GAP  = 8;
  localparam int unsigned LEN_W   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // DUT (CLK_DIV=4)
  logic             cmd_valid, cmd_ready, cmd_addr_en;
  logic [7:0]       cmd_op, rd_data;
  logic [23:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             rd_valid, done, busy, spi_clk, cs_n, mosi, wp_n, hold_n;
  logic             miso = 1'b0;

  // DUT2 (CLK_DIV=2)
  logic             cmd_valid2, cmd_ready2, cmd_addr_en2;
  logic [7:0]       cmd_op2, rd_data2;
  logic [23:0]      cmd_addr2;
  logic [LEN_W-1:0] cmd_len2;
  logic             rd_valid2, done2, busy2, spi_clk2, cs_n2, mosi2, wp_n2, hold_n2;
  logic             miso2 = 1'b0;

  spi_flash_master #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .LEN_W(LEN_W)) dut (
    .clk_i(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr_en(cmd_addr_en), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .busy(busy),
    .spi_clk(spi_clk), .cs_n(cs_n), .mosi(mosi), .miso(miso), .wp_n(wp_n), .hold_n(hold_n)
  );

  spi_flash_master #(.CLK_DIV(2), .CS_GAP(CS_GAP), .LEN_W(LEN_W)) dut2 (
    .clk_i(clk), .rst(rst), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_op(cmd_op2), .cmd_addr_en(cmd_addr_en2), .cmd_addr(cmd_addr2), .cmd_len(cmd_len2),
    .rd_valid(rd_valid2), .rd_data(rd_data2), .done(done2), .busy(busy2),
    .spi_clk(spi_clk2), .cs_n(cs_n2), .mosi(mosi2), .miso(miso2), .wp_n(wp_n2), .hold_n(hold_n2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor + bench slave for DUT ----------------
  int          cyc = 0;
  int          rise_cnt, fall_cnt, cs_low_cnt, rdv_cnt, done_cnt;
  int          edge_err, ready_busy_err, done_err;
  logic [63:0] mosi_bits;
  logic [7:0]  rd_q[$];
  int          t_cs_rise[$];
  int          t_cs_fall[$];
  logic        prev_sclk = 1'b0;
  logic        prev_cs_n = 1'b1;
  int          sl_hdr = 8;
  logic [31:0] sl_word = 32'd0;   // bytes the slave returns, first byte in [31:24]
  int          mon_n;

  always @(negedge clk) begin
    cyc++;
    if (spi_clk && !prev_sclk) begin
      rise_cnt++;
      mosi_bits = {mosi_bits[62:0], mosi};
    end
    // slave shifts read data out on falling spi_clk once the header is in
    if (!spi_clk && prev_sclk && !cs_n) begin
      fall_cnt++;
      if (fall_cnt >= sl_hdr) begin
        mon_n = fall_cnt - sl_hdr;
        miso  = (mon_n < 32) ? sl_word[31 - mon_n] : 1'b1;
      end
    end
    if (cs_n) fall_cnt = 0;
    if (!cs_n) cs_low_cnt++;
    if (cs_n != prev_cs_n) begin
      if (spi_clk || prev_sclk) edge_err++;
      if (cs_n) t_cs_rise.push_back(cyc);
      else      t_cs_fall.push_back(cyc);
    end
    if (!cs_n && cmd_ready) ready_busy_err++;
    if (rd_valid) begin
      rdv_cnt++;
      rd_q.push_back(rd_data);
    end
    if (done) begin
      done_cnt++;
      if (!(cs_n && !prev_cs_n)) done_err++;
    end
    prev_sclk = spi_clk;
    prev_cs_n = cs_n;
  end

  task automatic clear_mon();
    rise_cnt = 0; fall_cnt = 0; cs_low_cnt = 0; rdv_cnt = 0; done_cnt = 0;
    edge_err = 0; ready_busy_err = 0; done_err = 0;
    mosi_bits = 64'd0;
    rd_q.delete();
    t_cs_rise.delete();
    t_cs_fall.delete();
  endtask

  // ---------------- flash memory model for DUT2 ----------------
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    if (a == 24'h000010) return 8'h5A;
    if (a == 24'h000011) return 8'hC3;
    return 8'hFF;
  endfunction

  logic [31:0] sh2 = 32'd0;
  logic [23:0] addr2 = 24'd0;
  logic [7:0]  b2;
  logic        prev_sclk2 = 1'b0;
  int          fall2 = 0;
  int          n2;
  int          rdv2_cnt = 0;
  int          done2_cnt = 0;
  logic [7:0]  rd2_q[$];

  always @(negedge clk) begin
    if (spi_clk2 && !prev_sclk2) sh2 = {sh2[30:0], mosi2};
    if (!spi_clk2 && prev_sclk2 && !cs_n2) begin
      fall2++;
      if (fall2 == 32) addr2 = sh2[23:0];
      if (fall2 >= 32) begin
        n2    = fall2 - 32;
        b2    = mem_byte(addr2 + 24'(n2 / 8));
        miso2 = b2[7 - (n2 % 8)];
      end
    end
    if (cs_n2) fall2 = 0;
    if (rd_valid2) begin
      rdv2_cnt++;
      rd2_q.push_back(rd_data2);
    end
    if (done2) done2_cnt++;
    prev_sclk2 = spi_clk2;
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  op;
    logic        addr_en;
    logic [23:0] addr;
    logic [7:0]  len;
    logic [31:0] sb;         // slave data bytes == expected rd_data sequence
    int          exp_rises;
    logic [63:0] exp_bits;   // mosi at every rising spi_clk edge
    int          exp_cs_low;
    int          exp_rdv;
  } vec_t;

  vec_t vecs[4];

  task automatic wait_done(input int target, input int limit, input string name);
    int k;
    k = 0;
    while (done_cnt < target && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: done count %0d required %0d", name, done_cnt, target);
    end
  endtask

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (!cmd_ready && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL %s ready timeout: cmd_ready 0 required 1", name);
    end
  endtask

  task automatic start_cmd(input vec_t v);
    sl_hdr  = v.addr_en ? 32 : 8;
    sl_word = v.sb;
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_op      = v.op;
    cmd_addr_en = v.addr_en;
    cmd_addr    = v.addr;
    cmd_len     = v.len;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_and_check(input vec_t v, input string nm);
    clear_mon();
    wait_ready(nm);
    start_cmd(v);
    wait_done(1, 20000, nm);
    repeat (CS_GAP + 4) @(negedge clk);
    check({nm, " rises"},  64'(rise_cnt),   64'(v.exp_rises));
    check({nm, " bits"},   mosi_bits,       v.exp_bits);
    check({nm, " cs_low"}, 64'(cs_low_cnt), 64'(v.exp_cs_low));
    check({nm, " rdv"},    64'(rdv_cnt),    64'(v.exp_rdv));
    check({nm, " done"},   64'(done_cnt),   64'd1);
    check({nm, " edge/done align"}, 64'(edge_err + done_err + ready_busy_err), 64'd0);
    for (int j = 0; j < v.exp_rdv; j++) begin
      check($sformatf("%s rd_data[%0d]", nm, j),
            (j < rd_q.size()) ? 64'(rd_q[j]) : 64'hDEAD,
            64'(v.sb[31 - 8*j -: 8]));
    end
  endtask

  initial begin
    int acc, k, gap;

    vecs[0] = '{op: 8'h06, addr_en: 1'b0, addr: 24'h0, len: 8'd0, sb: 32'h0,
                exp_rises: 8,  exp_bits: 64'h06, exp_cs_low: 72, exp_rdv: 0};
    vecs[1] = '{op: 8'h20, addr_en: 1'b1, addr: 24'h012345, len: 8'd0, sb: 32'h0,
                exp_rises: 32, exp_bits: 64'h20012345, exp_cs_low: 264, exp_rdv: 0};
    vecs[2] = '{op: 8'h03, addr_en: 1'b1, addr: 24'h000100, len: 8'd3, sb: 32'hA53CFF00,
                exp_rises: 56, exp_bits: 64'h03000100000000, exp_cs_low: 456, exp_rdv: 3};
    vecs[3] = '{op: 8'h9F, addr_en: 1'b0, addr: 24'h0, len: 8'd2, sb: 32'hEF400000,
                exp_rises: 24, exp_bits: 64'h9F0000, exp_cs_low: 200, exp_rdv: 2};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 8'd0; cmd_addr_en = 1'b0; cmd_addr = 24'd0; cmd_len = '0;
    cmd_valid2 = 1'b0; cmd_op2 = 8'd0; cmd_addr_en2 = 1'b0; cmd_addr2 = 24'd0; cmd_len2 = '0;
    clear_mon();
    repeat (3) @(negedge clk);

    // reset state
    check("rst cs_n",      64'(cs_n),      64'd1);
    check("rst spi_clk",   64'(spi_clk),   64'd0);
    check("rst mosi",      64'(mosi),      64'd0);
    check("rst cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst busy",      64'(busy),      64'd0);
    check("rst rd_valid",  64'(rd_valid),  64'd0);
    check("rst rd_data",   64'(rd_data),   64'd0);
    check("rst done",      64'(done),      64'd0);
    check("rst wp/hold",   64'({wp_n, hold_n}), 64'd3);
    check("rst dut2 ready", 64'(cmd_ready2), 64'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // table-driven descriptors
    for (int i = 0; i < 4; i++) begin
      run_and_check(vecs[i], $sformatf("v%0d", i));
    end

    // back-to-back: cmd_valid held across two WREN descriptors
    clear_mon();
    sl_hdr = 8; sl_word = 32'd0;
    wait_ready("b2b");
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 8'h06; cmd_addr_en = 1'b0; cmd_addr = 24'd0; cmd_len = '0;
    acc = 0; k = 0;
    while (acc < 2 && k < 2000) begin
      if (cmd_ready) acc++;
      @(negedge clk);
      k++;
    end
    cmd_valid = 1'b0;
    check("b2b accepts", 64'(acc), 64'd2);
    wait_done(2, 2000, "b2b");
    repeat (CS_GAP + 4) @(negedge clk);
    check("b2b done",    64'(done_cnt),  64'd2);
    check("b2b rises",   64'(rise_cnt),  64'd16);
    check("b2b bits",    mosi_bits,      64'h0606);
    check("b2b cs_low",  64'(cs_low_cnt), 64'd144);
    check("b2b frames",  64'(t_cs_fall.size()), 64'd2);
    check("b2b ready while busy", 64'(ready_busy_err), 64'd0);
    gap = (t_cs_fall.size() >= 2 && t_cs_rise.size() >= 1) ? (t_cs_fall[1] - t_cs_rise[0]) : -1;
    check("b2b cs_n high gap", 64'(gap), 64'(CS_GAP + 1));

    // reset during the second data byte of a read
    clear_mon();
    wait_ready("rstmid");
    start_cmd(vecs[2]);
    k = 0;
    while (rdv_cnt < 1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("rstmid first byte seen", 64'(rdv_cnt), 64'd1);
    repeat (3 * 2 * CLK_DIV + 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid cs_n",      64'(cs_n),      64'd1);
    check("rstmid spi_clk",   64'(spi_clk),   64'd0);
    check("rstmid cmd_ready", 64'(cmd_ready), 64'd1);
    check("rstmid rd_valid",  64'(rd_valid),  64'd0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("rstmid no extra rd_valid", 64'(rdv_cnt),  64'd1);
    check("rstmid no done",           64'(done_cnt), 64'd0);
    run_and_check(vecs[0], "post-rst wren");

    // CLK_DIV=2 read against the memory model
    @(negedge clk);
    cmd_valid2 = 1'b1; cmd_op2 = 8'h03; cmd_addr_en2 = 1'b1; cmd_addr2 = 24'h000010; cmd_len2 = 8'd2;
    @(negedge clk);
    cmd_valid2 = 1'b0;
    k = 0;
    while (done2_cnt < 1 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("div2 done", 64'(done2_cnt), 64'd1);
    check("div2 rdv",  64'(rdv2_cnt),  64'd2);
    check("div2 byte0", (rd2_q.size() > 0) ? 64'(rd2_q[0]) : 64'hDEAD, 64'h5A);
    check("div2 byte1", (rd2_q.size() > 1) ? 64'(rd2_q[1]) : 64'hDEAD, 64'hC3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
